// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the RV64 integer datapath.
//   XLEN       : integer register / datapath width
//   REG_ADDR_W : architectural register index width
//   NREGS      : number of architectural integer registers
//   REG_ZERO   : index of the hard-wired zero register x0
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int REG_ZERO   = 0;

endpackage : riscv_pkg

// File: rtl/register_scoreboard.sv
// -----------------------------------------------------------------------------
// register_scoreboard
// One pending bit per architectural register. A bit is set when a producer
// for that register issues and cleared when its result is written back.
// The two ready lookups are combinational and include the same-cycle
// writeback bypass term.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   issueEn, issueRd  issuing instruction and its destination
//   wrEn, wrAddr      writeback strobe and destination
//   rs1Addr, rs2Addr  operand indices being looked up
//   rs1Ready, rs2Ready operand value is architecturally current
// -----------------------------------------------------------------------------
module register_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS  = riscv_pkg::NREGS,
    parameter int ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueRd,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [ADDR_W-1:0] rs1Addr,
    input  logic [ADDR_W-1:0] rs2Addr,
    output logic              rs1Ready,
    output logic              rs2Ready
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0] pending;

    logic issue_vld;
    logic wr_vld;

    assign issue_vld = issueEn && (issueRd != ZERO_IDX);
    assign wr_vld    = wrEn    && (wrAddr  != ZERO_IDX);

    // The set is written after the clear so that a register issued and
    // written back in the same cycle stays pending: the new producer is
    // still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wr_vld)
                pending[wrAddr] <= 1'b0;
            if (issue_vld)
                pending[issueRd] <= 1'b1;
        end
    end

    // A register is ready if it is x0, has no outstanding producer, or is
    // being written back this very cycle (the data port bypasses it).
    assign rs1Ready = (rs1Addr == ZERO_IDX) || !pending[rs1Addr] ||
                      (wrEn && (wrAddr == rs1Addr));
    assign rs2Ready = (rs2Addr == ZERO_IDX) || !pending[rs2Addr] ||
                      (wrEn && (wrAddr == rs2Addr));

endmodule : register_scoreboard

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// RV64 integer register file with write-first read bypass and a pending-write
// scoreboard. Its read ports feed the ALU X and Y operand paths.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rs1Addr, rs2Addr   read indices
//   rs1Data, rs2Data   combinational read data (x0 reads 0, writeback bypassed)
//   wrEn, wrAddr,
//   wrData             writeback port; writes to x0 are dropped
//   issueEn, issueRd   issuing instruction destination (marks register pending)
//   rs1Ready, rs2Ready operand is architecturally current
//   hazard             at least one operand is not ready
//
// ADDR_W must satisfy 2**ADDR_W == NREGS.
// -----------------------------------------------------------------------------
module register_file
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREGS  = riscv_pkg::NREGS,
    parameter int ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1Addr,
    input  logic [ADDR_W-1:0] rs2Addr,
    output logic [XLEN-1:0]   rs1Data,
    output logic [XLEN-1:0]   rs2Data,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [XLEN-1:0]   wrData,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueRd,
    output logic              rs1Ready,
    output logic              rs2Ready,
    output logic              hazard
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [XLEN-1:0] regs [NREGS];

    // Writeback. x0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wrEn && (wrAddr != ZERO_IDX)) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Read ports: x0 masking takes priority over the write-first bypass.
    always_comb begin
        rs1Data = regs[rs1Addr];
        if (rs1Addr == ZERO_IDX)
            rs1Data = '0;
        else if (wrEn && (wrAddr == rs1Addr))
            rs1Data = wrData;
    end

    always_comb begin
        rs2Data = regs[rs2Addr];
        if (rs2Addr == ZERO_IDX)
            rs2Data = '0;
        else if (wrEn && (wrAddr == rs2Addr))
            rs2Data = wrData;
    end

    register_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issueEn  (issueEn),
        .issueRd  (issueRd),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .rs1Addr  (rs1Addr),
        .rs2Addr  (rs2Addr),
        .rs1Ready (rs1Ready),
        .rs2Ready (rs2Ready)
    );

    assign hazard = ~(rs1Ready & rs2Ready);

endmodule : register_file

// File: doc/register_file.md
# register_file

- 64-bit RISC-V integer register file with a pending-write scoreboard.
- Sits directly upstream of the ALU: its two read ports supply the ALU X and Y operands (before immediate selection), and its write port takes the writeback result.
- The scoreboard tracks registers whose producer has issued but not yet written back, and flags operand hazards to the issue logic.

## Interface

Parameters:
- XLEN, 64, data width of each register and data port
- NREGS, 32, number of architectural registers
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W = NREGS

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset; asynchronous assert, active-low
- rs1Addr  in  ADDR_W  read port 1 index
- rs2Addr  in  ADDR_W  read port 2 index
- rs1Data  out  XLEN  read port 1 data, feeds ALU X
- rs2Data  out  XLEN  read port 2 data, feeds ALU Y path
- wrEn  in  1  writeback strobe
- wrAddr  in  ADDR_W  writeback destination index
- wrData  in  XLEN  writeback value (ALU result or load data)
- issueEn  in  1  an instruction with destination issueRd issues this cycle
- issueRd  in  ADDR_W  destination of the issuing instruction
- rs1Ready  out  1  rs1 value is architecturally current
- rs2Ready  out  1  rs2 value is architecturally current
- hazard  out  1  equals ~(rs1Ready & rs2Ready)

## Operation

Reset:
- rst_n low asynchronously clears all registers to 0 and all pending bits to 0.
- After reset, rsNData = 0, rsNReady = 1 and hazard = 0 for every address.
- If reset asserts mid-operation, any write or issue in that cycle is lost.

Register x0:
- Always reads 0.
- Writes to x0 are ignored.
- issueEn with issueRd = 0 is ignored; x0 is never pending.

Reads:
- Each read port is combinational, with write-first bypass.
- If wrEn = 1, wrAddr = rsNAddr and rsNAddr ≠ 0, then rsNData = wrData.
- Otherwise rsNData = regs[rsNAddr].
- Both ports may read the same address.

Writes:
- When wrEn = 1 and wrAddr ≠ 0, regs[wrAddr] ← wrData at the rising edge.

Scoreboard (one pending bit per register):
- Set at the edge when issueEn = 1 and issueRd ≠ 0.
- Cleared at the edge when wrEn = 1 and wrAddr ≠ 0.
- Same register issued and written back in the same cycle: the bit stays set, because the new producer is outstanding.
- Different registers issued and written back in the same cycle: both updates apply.

Ready:
- rsNReady = 1 when rsNAddr = 0, or when pending[rsNAddr] = 0.
- rsNReady = 1 also when a same-cycle writeback to rsNAddr is bypassing.
- Otherwise rsNReady = 0.

Write without an outstanding issue:
- Legal; the data is written and the pending bit stays 0.

## Timing

- Read latency is 0 cycles (combinational from rsNAddr, regs, and the bypass inputs).
- Write latency is 1 edge; the value is visible without bypass from the following cycle.
- A pending bit is set at the edge after issueEn, so rsNReady drops in the next cycle.
- Ready is combinational within the writeback cycle via the bypass term.
- No back-pressure on the write or issue inputs; one write and one issue are accepted every cycle.

## Structure

Shared package riscv_pkg holds:
- XLEN, REG_ADDR_W and NREGS constants
- REG_ZERO = 0 index constant

Sub-module register_scoreboard contains:
- the NREGS-bit pending vector
- its set/clear logic
- the two ready lookups, including the bypass term

The top level contains:
- the register array
- x0 masking
- read bypass muxes
- the hazard OR

## Test plan

- Reset then read all 32 addresses → rs1Data = rs2Data = 0, both ready = 1, hazard = 0.
- Write x5 = 0x0000_0000_DEAD_BEEF, next cycle read rs1 = rs2 = x5 → both ports return 0xDEADBEEF. Write x0 = 0xFFFF → x0 still reads 0.
- Bypass: in the same cycle wrEn = 1, wrAddr = 7, wrData = 123, rs1Addr = 7 → rs1Data = 123 combinationally, rs1Ready = 1.
- Scoreboard: issue rd = 3 → next cycle rs1Addr = 3 gives rs1Ready = 0 and hazard = 1. Writeback x3 = 750 → rs1Ready = 1 in that cycle, rs1Data = 750, and the bit is clear afterwards.
- Simultaneous issue and writeback of x9 → x9 updated, pending stays set, rs2Ready = 0 next cycle. Issue rd = 0 → rsNReady for x0 stays 1.
- Reset mid-operation: pending x4 and x4 = 64, assert rst_n low between edges → x4 reads 0 and is ready immediately, without waiting for a clock edge.
